imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake from a UART or debug link, assembles bytes little-endian into 32-bit instruction words, and issues one-cycle write strobes to the instruction memory write port at consecutive word addresses starting at 0. It sits between the host link and the instruction memory; word address N corresponds to PC = 4·N, i.e. PC[19:2].

## Interface
- INST_WIDTH_LENGTH, 32: instruction word width.
- WADDR_WIDTH, 18: word address width, covering 1<<18 words.
- clk  in  1  single clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load. Sampled only in IDLE or DONE.
- word_count  in  WADDR_WIDTH  number of words to load. Sampled with start.
- byte_data  in  8  incoming byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction memory write strobe, one cycle per word.
- waddr  out  WADDR_WIDTH  word address being written.
- wdata  out  INST_WIDTH_LENGTH  assembled instruction word.
- busy  out  1  a load is in progress.
- done  out  1  the load has completed. Held until the next start or rst.

## Operation
- States:
  - IDLE: nothing in progress.
  - LOAD: collecting bytes.
  - WRITE: issuing the write strobe.
  - DONE: load complete.
- IDLE/DONE + start:
  - word_count == 0: go to DONE with no writes.
  - Otherwise: latch word_count, clear word_addr and byte_idx, go to LOAD.
- LOAD:
  - byte_ready = 1.
  - A byte transfers when byte_valid && byte_ready.
  - Byte k (k = byte_idx, 0..3) goes to wdata[8k+7:8k], so the first byte is the LSB.
  - byte_idx increments and wraps 3→0.
  - On the transfer with byte_idx == 3, go to WRITE.
- WRITE:
  - we = 1, waddr = word_addr, wdata = assembled word. byte_ready = 0.
  - If word_addr == count−1: go to DONE.
  - Otherwise: word_addr+1, go to LOAD.
- DONE: done = 1. A new start restarts the load and clears done in the same edge.
- start is ignored while busy (LOAD/WRITE).
- byte_valid with byte_ready low: the byte is not consumed and the source must hold it.
- word_addr is not checked against memory depth. It cannot exceed WADDR_WIDTH because word_count is the same width.

## Timing
- Reset values:
  - state = IDLE
  - byte_ready = 0, we = 0, busy = 0, done = 0
  - waddr = 0, wdata = 0
  - byte_idx = 0, word_addr = 0
- rst asserted mid-load: next cycle is IDLE, the partial word is discarded, and no we is issued.
- Outputs are registered or decoded from the state register only; there is no combinational path from byte_valid to byte_ready.
- If the 4th byte is accepted at edge N, we is high in cycle N+1 (one cycle). LOAD resumes at N+2.
- Minimum 5 cycles per word (4 bytes plus 1 write).
- busy = 1 in LOAD and WRITE.
- done rises the cycle after the final WRITE.
- waddr and wdata stay stable while we is high.
- The memory latches on the rising edge where we = 1.

## Structure
- Shared header imem_defs.vh holds:
  - state encodings: IDLE = 2'd0, LOAD = 2'd1, WRITE = 2'd2, DONE = 2'd3
  - INST_WIDTH_LENGTH
  - WADDR_WIDTH
- Sub-module imem_word_assembler: byte_idx counter plus 4×8 shift/insert register. Outputs word_full on the 4th byte.
- Top level holds the FSM, word address counter and count compare.

## Test plan
- Load one word: start, word_count = 1, bytes 0x13,0x00,0x00,0x00 → one we, waddr = 0, wdata = 0x00000013; done = 1 the cycle after.
- Load three words with byte_valid toggling every other cycle → we at waddr 0, 1, 2 with correct little-endian words; no bytes lost or duplicated.
- Hold byte_valid low in the WRITE cycle, then high → byte_ready = 0 in WRITE; the byte is consumed in the first LOAD cycle.
- start with word_count = 0 → DONE next cycle, no we; start asserted again while busy during another load → ignored, waddr sequence unchanged.
- rst after 2 bytes of word 1 → IDLE, no we. A new start then rewrites waddr 0 with the fresh 4 bytes.
- start from DONE → done clears and a second load completes at waddr 0 onward.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared widths and FSM state encoding for the instruction memory boot loader.
package imem_loader_pkg;

    localparam int INST_WIDTH_LENGTH = 32;
    localparam int WADDR_WIDTH       = 18;
    localparam int BYTES_PER_WORD    = INST_WIDTH_LENGTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four bytes little-endian into one instruction word; word_full flags the 4th byte.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         clear,
    input  logic                         byte_en,
    input  logic [7:0]                   byte_data,
    output logic [INST_WIDTH_LENGTH-1:0] word,
    output logic                         word_full
);

    logic [1:0] byte_idx_reg;
    logic [7:0] lane_reg [BYTES_PER_WORD];

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            byte_idx_reg <= 2'd0;
        end else if (byte_en) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
        end
    end

    // Each lane captures only when the byte index points at it; lane 0 is the LSB.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (srst) begin
                    lane_reg[gi] <= 8'd0;
                end else if (byte_en && (byte_idx_reg == 2'(gi))) begin
                    lane_reg[gi] <= byte_data;
                end
            end
            assign word[8*gi +: 8] = lane_reg[gi];
        end
    endgenerate

    assign word_full = byte_en && (byte_idx_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: byte stream in, one write strobe per assembled word out.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WADDR_WIDTH-1:0]       word_count,
    input  logic [7:0]                   byte_data,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic                         we,
    output logic [WADDR_WIDTH-1:0]       waddr,
    output logic [INST_WIDTH_LENGTH-1:0] wdata,
    output logic                         busy,
    output logic                         done
);

    localparam logic [WADDR_WIDTH-1:0] ADDR_ONE = {{(WADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_reg;
    logic [WADDR_WIDTH-1:0]  word_addr_reg;
    logic [WADDR_WIDTH-1:0]  count_reg;
    logic                    byte_en;
    logic                    load_start;
    logic                    word_full;

    assign load_start = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE))
                        && (word_count != '0);
    assign byte_en    = byte_valid && (state_reg == ST_LOAD);

    imem_word_assembler u_assembler (
        .clk       (clk),
        .srst      (rst),
        .clear     (load_start),
        .byte_en   (byte_en),
        .byte_data (byte_data),
        .word      (wdata),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            word_addr_reg <= '0;
            count_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            count_reg     <= word_count;
                            word_addr_reg <= '0;
                            state_reg     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_full) begin
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (word_addr_reg == count_reg - ADDR_ONE) begin
                        state_reg <= ST_DONE;
                    end else begin
                        word_addr_reg <= word_addr_reg + ADDR_ONE;
                        state_reg     <= ST_LOAD;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // All handshake/status outputs decode straight off the state register, so
    // byte_valid never reaches byte_ready combinationally.
    assign byte_ready = (state_reg == ST_LOAD);
    assign we         = (state_reg == ST_WRITE);
    assign busy       = (state_reg == ST_LOAD) || (state_reg == ST_WRITE);
    assign done       = (state_reg == ST_DONE);
    assign waddr      = word_addr_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: stimulus queues expected writes, a monitor pops them.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic                         clk;
    logic                         rst;
    logic                         start;
    logic [WADDR_WIDTH-1:0]       word_count;
    logic [7:0]                   byte_data;
    logic                         byte_valid;
    logic                         byte_ready;
    logic                         we;
    logic [WADDR_WIDTH-1:0]       waddr;
    logic [INST_WIDTH_LENGTH-1:0] wdata;
    logic                         busy;
    logic                         done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WADDR_WIDTH-1:0]       exp_addr_q [$];
    logic [INST_WIDTH_LENGTH-1:0] exp_data_q [$];

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (!rst && we) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_we: got waddr %0h wdata %0h, expected no write", waddr, wdata);
            end else begin
                logic [WADDR_WIDTH-1:0]       ea;
                logic [INST_WIDTH_LENGTH-1:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                chk("waddr", 64'(waddr), 64'(ea));
                chk("wdata", 64'(wdata), 64'(ed));
                chk("ready_low_during_we", 64'(byte_ready), 64'd0);
                $display("write waddr=%0h wdata=%08h", waddr, wdata);
            end
        end
    end

    task automatic pulse_start(input logic [WADDR_WIDTH-1:0] cnt);
        start      = 1'b1;
        word_count = cnt;
        @(posedge clk); #1;
        start      = 1'b0;
        word_count = '0;
    endtask

    // Offers one byte, optionally after an idle cycle, and holds it until accepted.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        bit acc;
        if (gap) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        waited     = 0;
        acc        = 1'b0;
        while (!acc && waited < 64) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            waited++;
        end
        byte_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: got no accept in %0d cycles, expected accept", waited);
        end
    endtask

    // gap_mode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idles.
    task automatic do_load(input int n, input int gap_mode, input bit poke_start,
                           input bit use_fixed, input logic [31:0] fixed_word);
        logic [31:0] words [];
        words = new[n];
        for (int w = 0; w < n; w++) begin
            words[w] = (use_fixed && w == 0) ? fixed_word : $urandom;
            exp_addr_q.push_back(WADDR_WIDTH'(w));
            exp_data_q.push_back(words[w]);
        end
        $display("load n=%0d gap_mode=%0d poke_start=%0d", n, gap_mode, poke_start);
        pulse_start(WADDR_WIDTH'(n));
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("done_clear_after_start", 64'(done), 64'd0);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                bit gap;
                gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
                send_byte(words[w][8*k +: 8], gap);
            end
            chk("we_after_4th_byte", 64'(we), 64'd1);
            chk("ready_in_write", 64'(byte_ready), 64'd0);
            if (w == n - 1) begin
                @(posedge clk); #1;
                chk("done_after_last", 64'(done), 64'd1);
                chk("busy_after_last", 64'(busy), 64'd0);
                chk("we_single_cycle", 64'(we), 64'd0);
            end else if (poke_start && w == 0) begin
                pulse_start(WADDR_WIDTH'(7));
                chk("busy_ignores_start", 64'(busy), 64'd1);
            end else begin
                // byte_valid stays low through WRITE; the next byte must go in on the first LOAD cycle.
                @(posedge clk); #1;
                byte_valid = 1'b1;
                byte_data  = words[w + 1][7:0];
                @(negedge clk);
                chk("ready_first_load_cycle", 64'(byte_ready), 64'd1);
                @(posedge clk); #1;
                byte_valid = 1'b0;
                for (int k = 1; k < 4; k++) begin
                    send_byte(words[w + 1][8*k +: 8], gap_mode != 0);
                end
                chk("we_after_4th_byte_b", 64'(we), 64'd1);
                w++;
                if (w == n - 1) begin
                    @(posedge clk); #1;
                    chk("done_after_last_b", 64'(done), 64'd1);
                    chk("busy_after_last_b", 64'(busy), 64'd0);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_data  = 8'd0;
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);

        do_load(1, 0, 1'b0, 1'b1, 32'h0000_0013);
        do_load(3, 1, 1'b0, 1'b0, 32'h0);

        $display("start with word_count=0");
        pulse_start('0);
        chk("zero_count_done", 64'(done), 64'd1);
        chk("zero_count_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("zero_count_no_we", 64'(we), 64'd0);

        do_load(4, 2, 1'b1, 1'b0, 32'h0);

        $display("reset after two bytes");
        pulse_start(WADDR_WIDTH'(1));
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_we", 64'(we), 64'd0);
        chk("midrst_wdata", 64'(wdata), 64'd0);
        do_load(1, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        for (int i = 0; i < 6; i++) begin
            do_load($urandom_range(1, 6), 2, 1'b0, 1'b0, 32'h0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_addr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
